// File: rtl/data_memory_store.sv
// Word-addressed data memory with a memory-mapped output register.
// A post-reset sequencer zeroes the RAM before Ready is raised.
module data_memory_store #(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DATA_W  = 17,
    parameter logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic [DATA_W-1:0] IoOut,
    output logic [CNT_W-1:0]  StoreCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] io_q, io_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              is_io;

    assign is_io = (Address == IO_ADDR);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ready_d   = ready_q;
        io_d      = io_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = Address;
        mem_wdata = WriteData;
        if (!Reset_n) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
            ready_d = 1'b0;
            io_d    = '0;
            cnt_d   = '0;
        end else if (state_q == S_CLEAR) begin
            // Stores from the CPU are dropped while the sweep runs.
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == {ADDR_W{1'b1}}) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else if (MemWrite) begin
            if (is_io) begin
                io_d = WriteData;
            end else begin
                mem_we = 1'b1;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        ready_q <= ready_d;
        io_q    <= io_d;
        cnt_q   <= cnt_d;
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    // Old contents are visible until the edge, giving read-before-write.
    always_comb begin
        ReadData = '0;
        if (state_q == S_RUN && MemRead) begin
            ReadData = is_io ? io_q : mem_q[Address];
        end
    end

    assign Ready      = ready_q;
    assign IoOut      = io_q;
    assign StoreCount = cnt_q;

endmodule

// File: tb/tb_data_memory_store.sv
// Directed bench for data_memory_store: clear sequence, stores, loads,
// memory-mapped output, reset restart and counter saturation.
module tb_data_memory_store;

    logic        clk;
    logic        Reset_n;
    logic [7:0]  Address;
    logic [16:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [16:0] ReadData;
    logic        Ready;
    logic [16:0] IoOut;
    logic [15:0] StoreCount;

    int total = 0;
    int bad   = 0;

    data_memory_store dut (
        .Clock     (clk),
        .Reset_n   (Reset_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .IoOut     (IoOut),
        .StoreCount(StoreCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [16:0] wd;
        logic [16:0] exp_rd;
        logic [16:0] exp_io;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_clear(input string tag, input bit inject);
        for (int i = 1; i <= 256; i++) begin
            if (inject && i == 10) begin
                MemRead = 1'b1;
                Address = 8'd7;
                #1;
                chk({tag, "_clr_rd"}, 32'(ReadData), 32'h0);
                MemRead = 1'b0;
            end
            if (inject && i == 100) begin
                MemWrite  = 1'b1;
                Address   = 8'd7;
                WriteData = 17'h1234;
            end
            @(posedge clk);
            #1;
            if (i == 100) MemWrite = 1'b0;
            if (i == 255) chk({tag, "_ready255"}, 32'(Ready), 32'h0);
            if (i == 256) chk({tag, "_ready256"}, 32'(Ready), 32'h1);
        end
    endtask

    initial begin
        int nz;

        vecs[0]  = '{1'b1, 1'b0, 8'd5,   17'h1ABCD, 17'h0,     17'h0,     16'd1};
        vecs[1]  = '{1'b0, 1'b1, 8'd5,   17'h0,     17'h1ABCD, 17'h0,     16'd1};
        vecs[2]  = '{1'b0, 1'b1, 8'd6,   17'h0,     17'h0,     17'h0,     16'd1};
        vecs[3]  = '{1'b1, 1'b0, 8'hFF,  17'h0000A, 17'h0,     17'h0000A, 16'd2};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF,  17'h0,     17'h0000A, 17'h0000A, 16'd2};
        vecs[5]  = '{1'b1, 1'b0, 8'd254, 17'h12345, 17'h0,     17'h0000A, 16'd3};
        vecs[6]  = '{1'b0, 1'b1, 8'd254, 17'h0,     17'h12345, 17'h0000A, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 8'd3,   17'h00011, 17'h0,     17'h0000A, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 8'd3,   17'h00022, 17'h00011, 17'h0000A, 16'd5};
        vecs[9]  = '{1'b0, 1'b1, 8'd3,   17'h0,     17'h00022, 17'h0000A, 16'd5};
        vecs[10] = '{1'b0, 1'b1, 8'd7,   17'h0,     17'h0,     17'h0000A, 16'd5};
        vecs[11] = '{1'b1, 1'b0, 8'd9,   17'h1FFFF, 17'h0,     17'h0000A, 16'd6};
        vecs[12] = '{1'b0, 1'b1, 8'd9,   17'h0,     17'h1FFFF, 17'h0000A, 16'd6};
        vecs[13] = '{1'b0, 1'b0, 8'd9,   17'h0,     17'h0,     17'h0000A, 16'd6};
        vecs[14] = '{1'b1, 1'b1, 8'hFF,  17'h1FFFF, 17'h0000A, 17'h1FFFF, 16'd7};

        Reset_n   = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(Ready), 32'h0);
        chk("rst_io", 32'(IoOut), 32'h0);
        chk("rst_cnt", 32'(StoreCount), 32'h0);

        Reset_n = 1'b1;
        run_clear("init", 1'b1);
        chk("clr_cnt", 32'(StoreCount), 32'h0);
        chk("clr_io", 32'(IoOut), 32'h0);

        nz = 0;
        MemRead = 1'b1;
        for (int a = 0; a < 256; a++) begin
            Address = 8'(a);
            #1;
            if (ReadData !== 17'h0) nz++;
        end
        chk("mem_zero", 32'(nz), 32'h0);
        MemRead = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            MemWrite  = vecs[i].we;
            MemRead   = vecs[i].re;
            Address   = vecs[i].addr;
            WriteData = vecs[i].wd;
            #2;
            chk($sformatf("vec%0d_rd", i), 32'(ReadData), 32'(vecs[i].exp_rd));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_io", i), 32'(IoOut), 32'(vecs[i].exp_io));
            chk($sformatf("vec%0d_cnt", i), 32'(StoreCount),
                32'(vecs[i].exp_cnt));
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;

        Reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("run_rst_ready", 32'(Ready), 32'h0);
        chk("run_rst_io", 32'(IoOut), 32'h0);
        chk("run_rst_cnt", 32'(StoreCount), 32'h0);
        Reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        Reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_clr_ready", 32'(Ready), 32'h0);
        Reset_n = 1'b1;
        run_clear("restart", 1'b0);
        MemRead = 1'b1;
        Address = 8'd9;
        #1;
        chk("rezero_a9", 32'(ReadData), 32'h0);
        Address = 8'd5;
        #1;
        chk("rezero_a5", 32'(ReadData), 32'h0);
        MemRead = 1'b0;
        @(posedge clk);
        #1;

        MemWrite  = 1'b1;
        Address   = 8'd10;
        WriteData = 17'h15555;
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", 32'(StoreCount), 32'hFFFE);
        repeat (6) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(StoreCount), 32'hFFFF);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        chk("sat_rd", 32'(ReadData), 32'h15555);
        MemRead = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
